// File: rtl/alu_acc_pkg.sv
// rtl/alu_acc_pkg.sv - shared operation and state encodings for alu_accumulator
package alu_acc_pkg;

  typedef enum logic [2:0] {
    FN_ADD  = 3'b000,
    FN_MUL  = 3'b001,
    FN_SHL  = 3'b010,
    FN_LOAD = 3'b011,
    FN_SUB  = 3'b100,
    FN_SHR  = 3'b101,
    FN_XOR  = 3'b110,
    FN_CLR  = 3'b111
  } alu_fn_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-add multiplier, one multiplier bit per clock
module seq_multiplier #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8
) (
  input  logic                      Clock,
  input  logic                      Reset_b,
  input  logic                      start,
  input  logic [ACC_W-1:0]          multiplicand,
  input  logic [DATA_W-1:0]         multiplier,
  output logic                      done,
  output logic [ACC_W+DATA_W-1:0]   product
);

  localparam int P_W = ACC_W + DATA_W;
  localparam int CW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic [ACC_W-1:0]  mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [P_W-1:0]    partial_q;
  logic [CW-1:0]     count_q;
  logic              busy_q;
  logic [P_W-1:0]    addend;

  always_comb begin
    addend = '0;
    if (mplier_q[count_q]) addend = P_W'(mcand_q) << count_q;
  end

  // product includes the current step so the final bit lands on the done edge
  assign product = partial_q + addend;
  assign done    = busy_q && (count_q == LAST);

  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
    end else if (start) begin
      mcand_q   <= multiplicand;
      mplier_q  <= multiplier;
      partial_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b1;
    end else if (busy_q) begin
      partial_q <= product;
      if (done) begin
        busy_q  <= 1'b0;
        count_q <= '0;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_accumulator.sv
// rtl/alu_accumulator.sv - accumulator ALU with overflow flag and multi-cycle multiply
module alu_accumulator
  import alu_acc_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8
) (
  input  logic              Clock,
  input  logic              Reset_b,
  input  logic [DATA_W-1:0] Data,
  input  logic [2:0]        Function,
  input  logic              In_valid,
  output logic              In_ready,
  output logic [ACC_W-1:0]  ALU_reg_out,
  output logic              Overflow,
  output logic              Out_valid
);

  localparam int P_W = ACC_W + DATA_W;

  state_e                 state_q, state_d;
  logic [ACC_W-1:0]       acc_q;
  logic                   ovf_q;
  logic                   out_valid_q;
  logic                   accept;
  alu_fn_e                fn;
  logic [ACC_W-1:0]       d;
  logic [ACC_W:0]         sum, diff;
  logic [2*ACC_W-1:0]     shl_wide;
  logic                   shift_big;
  logic [ACC_W-1:0]       op_res;
  logic                   op_ovf;
  logic                   mul_start, mul_done;
  logic [P_W-1:0]         mul_product;
  logic                   wr_en;
  logic [ACC_W-1:0]       wr_val;
  logic                   wr_ovf;

  assign In_ready    = (state_q == ST_IDLE);
  assign accept      = In_valid && In_ready;
  assign fn          = alu_fn_e'(Function);
  assign d           = ACC_W'(Data);
  assign ALU_reg_out = acc_q;
  assign Overflow    = ovf_q;
  assign Out_valid   = out_valid_q;

  assign sum       = {1'b0, acc_q} + {1'b0, d};
  assign diff      = {1'b0, acc_q} - {1'b0, d};
  assign shl_wide  = {{ACC_W{1'b0}}, acc_q} << Data;
  assign shift_big = int'(Data) >= ACC_W;

  always_comb begin
    op_res = '0;
    op_ovf = 1'b0;
    case (fn)
      FN_ADD:  begin op_res = sum[ACC_W-1:0];  op_ovf = sum[ACC_W];  end
      FN_SUB:  begin op_res = diff[ACC_W-1:0]; op_ovf = diff[ACC_W]; end
      FN_SHL: begin
        if (shift_big) begin
          op_res = '0;
          op_ovf = |acc_q;
        end else begin
          op_res = shl_wide[ACC_W-1:0];
          op_ovf = |shl_wide[2*ACC_W-1:ACC_W];
        end
      end
      FN_LOAD: op_res = d;
      FN_SHR:  op_res = shift_big ? '0 : (acc_q >> Data);
      FN_XOR:  op_res = acc_q ^ d;
      default: op_res = '0;
    endcase
  end

  seq_multiplier #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mul (
    .Clock        (Clock),
    .Reset_b      (Reset_b),
    .start        (mul_start),
    .multiplicand (acc_q),
    .multiplier   (Data),
    .done         (mul_done),
    .product      (mul_product)
  );

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    wr_en     = 1'b0;
    wr_val    = op_res;
    wr_ovf    = op_ovf;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (fn == FN_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          wr_en   = 1'b1;
          wr_val  = mul_product[ACC_W-1:0];
          wr_ovf  = |mul_product[P_W-1:ACC_W];
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= wr_en;
      if (wr_en) begin
        acc_q <= wr_val;
        ovf_q <= wr_ovf;
      end
    end
  end

endmodule

// File: tb/tb_alu_accumulator.sv
// tb/tb_alu_accumulator.sv - directed self-checking bench for alu_accumulator
module tb_alu_accumulator;

  localparam logic [2:0] ADD = 3'b000, MUL = 3'b001, SHL = 3'b010, LOAD = 3'b011;
  localparam logic [2:0] SUB = 3'b100, SHR = 3'b101, XOR = 3'b110, CLR = 3'b111;

  logic       Clock = 1'b0;
  logic       Reset_b = 1'b0;
  logic [3:0] Data = '0;
  logic [2:0] Function = '0;
  logic       In_valid = 1'b0;
  logic       In_ready;
  logic [7:0] ALU_reg_out;
  logic       Overflow;
  logic       Out_valid;

  int n_cmp = 0;
  int n_bad = 0;

  alu_accumulator #(.DATA_W(4), .ACC_W(8)) dut (
    .Clock       (Clock),
    .Reset_b     (Reset_b),
    .Data        (Data),
    .Function    (Function),
    .In_valid    (In_valid),
    .In_ready    (In_ready),
    .ALU_reg_out (ALU_reg_out),
    .Overflow    (Overflow),
    .Out_valid   (Out_valid)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic cmd(input logic [2:0] f, input logic [3:0] v);
    Function = f;
    Data     = v;
    In_valid = 1'b1;
    tick();
    In_valid = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [7:0] acc, input logic ovf);
    chk({tag, ".acc"}, ALU_reg_out, acc);
    chk({tag, ".ovf"}, Overflow, ovf);
    chk({tag, ".ov"}, Out_valid, 1'b1);
  endtask

  initial begin
    // 1: reset with a pending command
    Reset_b = 1'b0; In_valid = 1'b1; Function = LOAD; Data = 4'h5;
    tick(); tick();
    chk("rst.acc", ALU_reg_out, 8'h00);
    chk("rst.ovf", Overflow, 1'b0);
    chk("rst.ov", Out_valid, 1'b0);
    chk("rst.rdy", In_ready, 1'b1);
    In_valid = 1'b0; Reset_b = 1'b1;
    tick();
    chk("rst.noacc", ALU_reg_out, 8'h00);
    chk("rst.noov", Out_valid, 1'b0);

    // 2: back-to-back LOAD/ADD, then ADD chain up to carry
    cmd(LOAD, 4'd9);  chk_res("load9", 8'h09, 1'b0);
    cmd(ADD, 4'd15);  chk_res("add15", 8'h18, 1'b0);
    tick();
    chk("add.ovpulse", Out_valid, 1'b0);
    cmd(LOAD, 4'hF);  chk_res("loadF", 8'h0F, 1'b0);
    for (int i = 1; i <= 16; i++) cmd(ADD, 4'hF);
    chk_res("add16", 8'hFF, 1'b0);
    cmd(ADD, 4'hF);   chk_res("add17", 8'h0E, 1'b1);
    tick();
    chk("ovf.hold", Overflow, 1'b1);

    // 3: multiply 12*13 then *2
    cmd(LOAD, 4'd12); chk_res("load12", 8'h0C, 1'b0);
    cmd(MUL, 4'd13);
    chk("mul.rdy0", In_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mul.busy", In_ready, 1'b0);
      chk("mul.oldacc", ALU_reg_out, 8'h0C);
      chk("mul.noov", Out_valid, 1'b0);
    end
    tick();
    chk_res("mul13", 8'h9C, 1'b0);
    chk("mul.rdy1", In_ready, 1'b1);
    tick();
    chk("mul.ovpulse", Out_valid, 1'b0);
    cmd(MUL, 4'd2);
    repeat (4) tick();
    chk_res("mul2", 8'h38, 1'b1);

    // 4: shifts, subtract borrow, xor, clear
    cmd(LOAD, 4'd1);  chk_res("load1", 8'h01, 1'b0);
    cmd(SHL, 4'd7);   chk_res("shl7", 8'h80, 1'b0);
    cmd(SHL, 4'd1);   chk_res("shl1", 8'h00, 1'b1);
    cmd(LOAD, 4'd3);  chk_res("load3", 8'h03, 1'b0);
    cmd(SUB, 4'd5);   chk_res("sub5", 8'hFE, 1'b1);
    cmd(SHR, 4'd9);   chk_res("shr9", 8'h00, 1'b0);
    cmd(LOAD, 4'd5);  chk_res("load5", 8'h05, 1'b0);
    cmd(XOR, 4'd3);   chk_res("xor3", 8'h06, 1'b0);
    cmd(SHL, 4'd9);   chk_res("shl9", 8'h00, 1'b1);
    cmd(CLR, 4'd0);   chk_res("clr", 8'h00, 1'b0);
    cmd(LOAD, 4'd9);  cmd(SUB, 4'd4); chk_res("sub4", 8'h05, 1'b0);

    // 5: reset aborts a multiply in flight
    cmd(LOAD, 4'd7);  chk_res("load7", 8'h07, 1'b0);
    cmd(MUL, 4'd15);
    tick();
    Reset_b = 1'b0;
    tick();
    Reset_b = 1'b1;
    chk("abort.acc", ALU_reg_out, 8'h00);
    chk("abort.ov", Out_valid, 1'b0);
    chk("abort.rdy", In_ready, 1'b1);
    tick();
    chk("abort.noov", Out_valid, 1'b0);
    chk("abort.acc2", ALU_reg_out, 8'h00);
    cmd(LOAD, 4'd2);  chk_res("abort.load2", 8'h02, 1'b0);

    // 6: inputs toggling during a multiply are ignored; next cmd taken in Out_valid cycle
    cmd(LOAD, 4'd3);
    Function = MUL; Data = 4'd5; In_valid = 1'b1;
    tick();
    Function = CLR;  Data = 4'd1; tick(); chk("ign.acc1", ALU_reg_out, 8'h03);
    Function = ADD;  Data = 4'd7; tick(); chk("ign.acc2", ALU_reg_out, 8'h03);
    Function = LOAD; Data = 4'd9; tick(); chk("ign.acc3", ALU_reg_out, 8'h03);
    chk("ign.rdy", In_ready, 1'b0);
    tick();
    chk_res("ign.mul", 8'h0F, 1'b0);
    chk("ign.rdy1", In_ready, 1'b1);
    tick();
    In_valid = 1'b0;
    chk_res("ign.next", 8'h09, 1'b0);
    tick();
    chk("ign.end", Out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
